fp32_to_fixed: RTL and testbench
================================

# fp32_to_fixed

Downstream consumer of the floating-point MAC accumulator. It converts an IEEE-754 single-precision result into a signed two's-complement fixed-point word. Rounding is round-to-nearest-even, out-of-range values saturate, and NaN, saturation and inexact flags are reported per sample. The block is a 2-stage pipeline with a valid/ready handshake on both sides. It accepts one sample per cycle when not back-pressured.

## Interface
Parameters:
- OUT_W, 16, output word width; legal range 8..32.
- FRAC_W, 8, number of fractional bits in the output; legal range 0..OUT_W-1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept in_data this cycle.
- in_data  in  32  fp32 value (sign, exp[30:23], man[22:0]).
- out_valid  out  1  out_* fields are valid.
- out_ready  in  1  downstream accepts the output this cycle.
- out_data  out  OUT_W  signed fixed-point result, Q(OUT_W-FRAC_W-1).FRAC_W.
- out_sat  out  1  result was clipped to the positive or negative limit.
- out_nan  out  1  input was NaN; out_data is 0.
- out_inexact  out  1  nonzero bits were discarded by rounding or flush.

## Operation
- Conversion target: round(value * 2^FRAC_W) into range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Input classes, decoded in stage 1:
  - exp=0: zero or subnormal, flushed to 0. out_inexact=1 iff man!=0.
  - exp=255 with man!=0: NaN. Result is 0 with out_nan=1; other flags are 0.
  - exp=255 with man=0: infinity. Result is 0x7FF..F (positive) or 0x800..0 (negative), with out_sat=1.
  - Otherwise: normal number.
- Normal numbers:
  - Mantissa M = {1, man}, 24 bits.
  - Shift k = exp - 150 + FRAC_W, computed as signed 10-bit.
  - k >= 0: magnitude = M << k, held in OUT_W+1 bits.
    - An ovf bit is set if 23+k >= OUT_W+1, i.e. bits are lost.
  - k < 0: magnitude = M >> (-k), with guard = first dropped bit and sticky = OR of the remaining dropped bits.
    - For -k >= 25, magnitude=0, guard=0, sticky=1.
    - For -k = 24, magnitude=0, guard=1 (the leading 1), sticky=OR(man).
- Stage 2: round, saturate, negate.
  - Round up when guard && (sticky || magnitude[0]).
  - out_inexact = guard | sticky.
  - Saturate positive when ovf or rounded magnitude > 2^(OUT_W-1)-1. Result 0x7F..F, out_sat=1.
  - Saturate negative when ovf or rounded magnitude > 2^(OUT_W-1). Result 0x80..0, out_sat=1.
  - A rounding carry that crosses the limit saturates.
  - Negative, in range: out_data = -magnitude in two's complement.
  - -0.0 gives 0.
- Handshake:
  - Stage enables: e2 = !out_valid || out_ready; e1 = !s1_valid || e2; in_ready = e1.
  - A transfer happens when valid && ready on the same cycle.
  - Output fields hold stable while out_valid && !out_ready.
  - Sample order is preserved, with no drops and no duplicates.
- Reset:
  - All valid bits, out_data and all flags clear to 0 immediately on rst, including mid-stream.
  - In-flight samples are discarded.
  - in_ready reads 1 as soon as rst deasserts.

## Timing
- Latency: a sample accepted on edge N presents on out_* after edge N+2, when there are no stalls.
- Throughput: 1 sample/cycle with out_ready held high.
- Stall: with out_ready low, the pipe fills to 2 samples, then in_ready drops in the same cycle.
  - in_ready is combinational from out_ready and the internal valid bits.
  - There is no combinational path from in_data to any output.
- Simultaneous events: when out accepts and in offers on the same cycle, both transfer and the pipe advances.
- Each flag is registered alongside its out_data.

## Test plan
All scenarios use OUT_W=16, FRAC_W=8.
- Basic values, streamed back-to-back:
  - 0x3F800000 -> 0x0100.
  - 0xC0200000 -> 0xFD80.
  - 0x00000000 -> 0x0000.
  - All three return with no flags, 2 cycles latency and 1 per cycle.
- RNE ties:
  - 0x3BC00000 (1.5 LSB) -> 0x0002, inexact.
  - 0x3C200000 (2.5 LSB) -> 0x0002, inexact.
  - 0x3B800001 -> 0x0001, inexact.
  - 0x00400000 (subnormal) -> 0x0000, inexact.
- Saturation:
  - 0x43480000 (+200) -> 0x7FFF, sat.
  - 0xC3000000 (-128) -> 0x8000, not sat.
  - 0xC3480000 (-200) -> 0x8000, sat.
  - 0x42FFFFFF (127.99999) -> 0x7FFF, sat, inexact, via rounding carry.
- Specials:
  - 0x7FC00000 -> 0x0000, nan only.
  - 0x7F800000 -> 0x7FFF, sat.
  - 0xFF800000 -> 0x8000, sat.
- Backpressure:
  - Offer 5 samples with out_ready=0 for 6 cycles. in_ready drops after 2 accepts and out_data holds stable.
  - Release out_ready: all 5 samples emerge in order with no gaps; random out_ready toggling gives no loss.
- Reset mid-stream:
  - Assert rst with 2 samples in flight. out_valid=0 and out_data=0 immediately; those samples never appear.
  - The first post-reset input appears after 2 cycles.

Source files
------------

// File: rtl/fp32_to_fixed.sv
// fp32 to signed Q-format fixed-point converter: 2-stage pipeline with valid/ready on both sides.
// Stage 1 decodes and aligns the mantissa; stage 2 rounds to nearest-even, saturates and negates.
module fp32_to_fixed #(
    parameter int OUT_W  = 16,
    parameter int FRAC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_sat,
    output logic              out_nan,
    output logic              out_inexact
);

    localparam int MAG_W = OUT_W + 1;
    localparam logic [MAG_W:0]   POS_LIM = {3'b000, {(OUT_W-1){1'b1}}};
    localparam logic [MAG_W:0]   NEG_LIM = {3'b001, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};

    logic stage2En;
    logic stage1En;

    logic             s1Valid_q;
    logic             s1Sign_q,   s1Sign_d;
    logic             s1Nan_q,    s1Nan_d;
    logic             s1Ovf_q,    s1Ovf_d;
    logic             s1Guard_q,  s1Guard_d;
    logic             s1Sticky_q, s1Sticky_d;
    logic [MAG_W-1:0] s1Mag_q,    s1Mag_d;

    logic             outValid_q;
    logic [OUT_W-1:0] outData_q,    outData_d;
    logic             outSat_q,     outSat_d;
    logic             outNan_q,     outNan_d;
    logic             outInexact_q, outInexact_d;

    logic [7:0]        expo;
    logic [22:0]       man;
    logic [23:0]       mant;
    logic [55:0]       mantExt;
    logic signed [9:0] shiftK;
    logic [9:0]        shiftNeg;
    logic [47:0]       rightWide;
    logic [55:0]       rightMag;

    logic         roundUp;
    logic [MAG_W:0] rounded;

    assign stage2En = !outValid_q || out_ready;
    assign stage1En = !s1Valid_q || stage2En;
    assign in_ready = stage1En;

    assign expo     = in_data[30:23];
    assign man      = in_data[22:0];
    assign mant     = {1'b1, man};
    assign mantExt  = {32'b0, mant};
    assign shiftK   = 10'(expo) - 10'd150 + 10'(FRAC_W);
    assign shiftNeg = -shiftK;
    // Low 24 bits of rightWide are the bits shifted out: guard is the top one, sticky the rest.
    assign rightWide = {mant, 24'b0} >> shiftNeg;
    assign rightMag  = {32'b0, rightWide[47:24]};

    always_comb begin
        s1Sign_d   = in_data[31];
        s1Nan_d    = 1'b0;
        s1Ovf_d    = 1'b0;
        s1Guard_d  = 1'b0;
        s1Sticky_d = 1'b0;
        s1Mag_d    = '0;
        if (expo == 8'd0) begin
            s1Sticky_d = |man;
        end else if (expo == 8'hFF) begin
            if (man != 23'd0) begin
                s1Nan_d = 1'b1;
            end else begin
                s1Ovf_d = 1'b1;
            end
        end else if (!shiftK[9]) begin
            s1Ovf_d = ({22'b0, shiftK} + 32'd23) >= 32'(MAG_W);
            s1Mag_d = MAG_W'(mantExt << shiftK[7:0]);
        end else if (shiftNeg >= 10'd25) begin
            s1Sticky_d = 1'b1;
        end else begin
            s1Mag_d    = rightMag[MAG_W-1:0];
            s1Guard_d  = rightWide[23];
            s1Sticky_d = |rightWide[22:0];
            s1Ovf_d    = |(rightMag >> MAG_W);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Valid_q  <= 1'b0;
            s1Sign_q   <= 1'b0;
            s1Nan_q    <= 1'b0;
            s1Ovf_q    <= 1'b0;
            s1Guard_q  <= 1'b0;
            s1Sticky_q <= 1'b0;
            s1Mag_q    <= '0;
        end else if (stage1En) begin
            s1Valid_q <= in_valid;
            if (in_valid) begin
                s1Sign_q   <= s1Sign_d;
                s1Nan_q    <= s1Nan_d;
                s1Ovf_q    <= s1Ovf_d;
                s1Guard_q  <= s1Guard_d;
                s1Sticky_q <= s1Sticky_d;
                s1Mag_q    <= s1Mag_d;
            end
        end
    end

    // Rounding carry is kept one bit wider so a carry past the limit still saturates.
    assign roundUp = s1Guard_q && (s1Sticky_q || s1Mag_q[0]);
    assign rounded = {1'b0, s1Mag_q} + (MAG_W+1)'(roundUp);

    always_comb begin
        outData_d    = '0;
        outSat_d     = 1'b0;
        outNan_d     = 1'b0;
        outInexact_d = 1'b0;
        if (s1Nan_q) begin
            outNan_d = 1'b1;
        end else begin
            outInexact_d = s1Guard_q | s1Sticky_q;
            if (!s1Sign_q) begin
                if (s1Ovf_q || rounded > POS_LIM) begin
                    outData_d = MAX_POS;
                    outSat_d  = 1'b1;
                end else begin
                    outData_d = rounded[OUT_W-1:0];
                end
            end else begin
                if (s1Ovf_q || rounded > NEG_LIM) begin
                    outData_d = MIN_NEG;
                    outSat_d  = 1'b1;
                end else begin
                    outData_d = -rounded[OUT_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outValid_q   <= 1'b0;
            outData_q    <= '0;
            outSat_q     <= 1'b0;
            outNan_q     <= 1'b0;
            outInexact_q <= 1'b0;
        end else if (stage2En) begin
            outValid_q <= s1Valid_q;
            if (s1Valid_q) begin
                outData_q    <= outData_d;
                outSat_q     <= outSat_d;
                outNan_q     <= outNan_d;
                outInexact_q <= outInexact_d;
            end
        end
    end

    assign out_valid   = outValid_q;
    assign out_data    = outData_q;
    assign out_sat     = outSat_q;
    assign out_nan     = outNan_q;
    assign out_inexact = outInexact_q;

endmodule

// File: tb/tb_fp32_to_fixed.sv
// Directed bench for fp32_to_fixed (OUT_W=16, FRAC_W=8): values, rounding, saturation,
// specials, backpressure and mid-stream reset, each checked against hand-computed results.
module tb_fp32_to_fixed;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sat;
    logic        out_nan;
    logic        out_inexact;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [15:0] outDataQ[$];
    logic [2:0]  outFlagQ[$];
    int          outEdgeQ[$];
    int          inEdgeQ[$];

    fp32_to_fixed #(.OUT_W(16), .FRAC_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_sat(out_sat),
        .out_nan(out_nan),
        .out_inexact(out_inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Transfers are logged mid-cycle; inEdgeQ holds the edge that opened the accepting cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) inEdgeQ.push_back(cyc);
            if (out_valid && out_ready) begin
                outDataQ.push_back(out_data);
                outFlagQ.push_back({out_sat, out_nan, out_inexact});
                outEdgeQ.push_back(cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic syncEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic clearQs();
        outDataQ.delete();
        outFlagQ.delete();
        outEdgeQ.delete();
        inEdgeQ.delete();
    endtask

    task automatic pushSample(input logic [31:0] v);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_data  = v;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL push_timeout in_ready never high for %h", v);
        end
    endtask

    task automatic waitOutputs(input int n);
        for (int c = 0; c < 200 && outDataQ.size() < n; c++) syncEdge();
        if (outDataQ.size() < n) begin
            checks++;
            errors++;
            $display("[TB] FAIL output_timeout got %0d outputs expected %0d", outDataQ.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 32'h0;
        out_ready = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_data, out_sat, out_nan, out_inexact} !== 20'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %h expected 0",
                     {out_valid, out_data, out_sat, out_nan, out_inexact});
        end
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready got %b expected 1", in_ready);
        end
        syncEdge();
    endtask

    task automatic test_basic();
        logic [31:0] vin[3];
        logic [15:0] vexp[3];
        vin  = '{32'h3F800000, 32'hC0200000, 32'h00000000};
        vexp = '{16'h0100, 16'hFD80, 16'h0000};
        clearQs();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) pushSample(vin[i]);
        waitOutputs(3);
        for (int i = 0; i < 3; i++) begin
            if (i < outDataQ.size() && i < inEdgeQ.size()) begin
                checks++;
                if (outDataQ[i] !== vexp[i] || outFlagQ[i] !== 3'b000) begin
                    errors++;
                    $display("[TB] FAIL basic_%0d got %h/%b expected %h/000", i, outDataQ[i], outFlagQ[i], vexp[i]);
                end
                checks++;
                if (outEdgeQ[i] - inEdgeQ[i] !== 2) begin
                    errors++;
                    $display("[TB] FAIL basic_latency_%0d got %0d expected 2", i, outEdgeQ[i] - inEdgeQ[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (outEdgeQ[i] - outEdgeQ[i-1] !== 1) begin
                        errors++;
                        $display("[TB] FAIL basic_rate_%0d got %0d expected 1", i, outEdgeQ[i] - outEdgeQ[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_rne();
        logic [31:0] vin[4];
        logic [15:0] vexp[4];
        logic [2:0]  fexp[4];
        vin  = '{32'h3BC00000, 32'h3C200000, 32'h3B800001, 32'h00400000};
        vexp = '{16'h0002, 16'h0002, 16'h0001, 16'h0000};
        fexp = '{3'b001, 3'b001, 3'b001, 3'b001};
        clearQs();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) pushSample(vin[i]);
        waitOutputs(4);
        for (int i = 0; i < 4; i++) begin
            if (i < outDataQ.size()) begin
                checks++;
                if (outDataQ[i] !== vexp[i] || outFlagQ[i] !== fexp[i]) begin
                    errors++;
                    $display("[TB] FAIL rne_%0d in %h got %h/%b expected %h/%b",
                             i, vin[i], outDataQ[i], outFlagQ[i], vexp[i], fexp[i]);
                end
            end
        end
    endtask

    task automatic test_saturation();
        logic [31:0] vin[4];
        logic [15:0] vexp[4];
        logic [2:0]  fexp[4];
        vin  = '{32'h43480000, 32'hC3000000, 32'hC3480000, 32'h42FFFFFF};
        vexp = '{16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF};
        fexp = '{3'b100, 3'b000, 3'b100, 3'b101};
        clearQs();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) pushSample(vin[i]);
        waitOutputs(4);
        for (int i = 0; i < 4; i++) begin
            if (i < outDataQ.size()) begin
                checks++;
                if (outDataQ[i] !== vexp[i] || outFlagQ[i] !== fexp[i]) begin
                    errors++;
                    $display("[TB] FAIL sat_%0d in %h got %h/%b expected %h/%b",
                             i, vin[i], outDataQ[i], outFlagQ[i], vexp[i], fexp[i]);
                end
            end
        end
    endtask

    task automatic test_specials();
        logic [31:0] vin[4];
        logic [15:0] vexp[4];
        logic [2:0]  fexp[4];
        vin  = '{32'h7FC00000, 32'h7F800000, 32'hFF800000, 32'h80000000};
        vexp = '{16'h0000, 16'h7FFF, 16'h8000, 16'h0000};
        fexp = '{3'b010, 3'b100, 3'b100, 3'b000};
        clearQs();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) pushSample(vin[i]);
        waitOutputs(4);
        for (int i = 0; i < 4; i++) begin
            if (i < outDataQ.size()) begin
                checks++;
                if (outDataQ[i] !== vexp[i] || outFlagQ[i] !== fexp[i]) begin
                    errors++;
                    $display("[TB] FAIL special_%0d in %h got %h/%b expected %h/%b",
                             i, vin[i], outDataQ[i], outFlagQ[i], vexp[i], fexp[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] vin[5];
        logic [15:0] vexp[5];
        logic [2:0]  fexp[5];
        vin  = '{32'h3F800000, 32'hC0200000, 32'h00000000, 32'h3BC00000, 32'h43480000};
        vexp = '{16'h0100, 16'hFD80, 16'h0000, 16'h0002, 16'h7FFF};
        fexp = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b100};
        clearQs();
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) pushSample(vin[i]);
            end
            begin
                for (int i = 1; i <= 6; i++) begin
                    @(negedge clk);
                    if (i >= 3) begin
                        checks++;
                        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'h0100) begin
                            errors++;
                            $display("[TB] FAIL stall_hold_%0d got ready=%b valid=%b data=%h expected 0/1/0100",
                                     i, in_ready, out_valid, out_data);
                        end
                    end
                end
                checks++;
                if (inEdgeQ.size() !== 2) begin
                    errors++;
                    $display("[TB] FAIL stall_accepts got %0d expected 2", inEdgeQ.size());
                end
                syncEdge();
                out_ready = 1'b1;
            end
        join
        waitOutputs(5);
        for (int i = 0; i < 5; i++) begin
            if (i < outDataQ.size()) begin
                checks++;
                if (outDataQ[i] !== vexp[i] || outFlagQ[i] !== fexp[i]) begin
                    errors++;
                    $display("[TB] FAIL bp_order_%0d got %h/%b expected %h/%b", i, outDataQ[i], outFlagQ[i], vexp[i], fexp[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (outEdgeQ[i] - outEdgeQ[i-1] !== 1) begin
                        errors++;
                        $display("[TB] FAIL bp_gap_%0d got %0d expected 1", i, outEdgeQ[i] - outEdgeQ[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_random_ready();
        logic [31:0] vin[8];
        logic [15:0] vexp[8];
        vin  = '{32'h3F800000, 32'hC0200000, 32'h3BC00000, 32'h3C200000,
                 32'hC3000000, 32'h3B800001, 32'h43480000, 32'hBF800000};
        vexp = '{16'h0100, 16'hFD80, 16'h0002, 16'h0002,
                 16'h8000, 16'h0001, 16'h7FFF, 16'hFF00};
        clearQs();
        fork
            begin
                for (int i = 0; i < 8; i++) pushSample(vin[i]);
            end
            begin
                for (int c = 0; c < 30; c++) begin
                    out_ready = 1'($urandom_range(0, 1));
                    syncEdge();
                end
                out_ready = 1'b1;
            end
        join
        waitOutputs(8);
        checks++;
        if (outDataQ.size() !== 8) begin
            errors++;
            $display("[TB] FAIL random_count got %0d expected 8", outDataQ.size());
        end
        for (int i = 0; i < 8; i++) begin
            if (i < outDataQ.size()) begin
                checks++;
                if (outDataQ[i] !== vexp[i]) begin
                    errors++;
                    $display("[TB] FAIL random_order_%0d got %h expected %h", i, outDataQ[i], vexp[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        clearQs();
        out_ready = 1'b0;
        pushSample(32'h3F800000);
        pushSample(32'h43480000);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_data, out_sat, out_nan, out_inexact} !== 20'h0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs got %h expected 0",
                     {out_valid, out_data, out_sat, out_nan, out_inexact});
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_in_ready got %b expected 1", in_ready);
        end
        syncEdge();
        out_ready = 1'b1;
        clearQs();
        repeat (5) syncEdge();
        checks++;
        if (outDataQ.size() !== 0) begin
            errors++;
            $display("[TB] FAIL midreset_flushed got %0d outputs expected 0", outDataQ.size());
        end
        pushSample(32'hC0200000);
        waitOutputs(1);
        if (outDataQ.size() > 0 && inEdgeQ.size() > 0) begin
            checks++;
            if (outDataQ[0] !== 16'hFD80 || outEdgeQ[0] - inEdgeQ[0] !== 2) begin
                errors++;
                $display("[TB] FAIL midreset_first got %h latency %0d expected FD80 latency 2",
                         outDataQ[0], outEdgeQ[0] - inEdgeQ[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rne();
        test_saturation();
        test_specials();
        test_backpressure();
        test_random_ready();
        test_reset_midstream();
        repeat (3) syncEdge();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
